cache_req_arb: RTL and testbench

CACHE_REQ_ARB -- requirements
Module: cache_req_arb

---
 rtl/cache_req_arb_pkg.sv | 18 +
 rtl/req_fifo.sv | 45 ++++
 rtl/cache_req_arb.sv | 165 ++++++++++++++++
 tb/tb_cache_req_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_arb_pkg.sv
// Shared definitions for the two-port cache request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_req_arb_pkg;

  localparam int DEF_ADDR_W = 48;
  localparam int DEF_OP_W   = 8;

  localparam logic [7:0] OP_READ  = 8'h72;
  localparam logic [7:0] OP_WRITE = 8'h77;

  // Request as seen on a requester port at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_OP_W-1:0]   op;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Per-port request queue, DEPTH entries of W bits, registered head-of-queue read.
// Latency: an entry pushed at edge E is visible on head_o after E.
// Backpressure: full_o is purely registered; a pop never frees a slot for a same-cycle push.
module req_fifo #(
  parameter int W     = 56,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [W-1:0]  mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cache_req_arb.sv
// Two-port round-robin arbiter feeding one registered request slot toward cache_engine.
// Latency: request accepted at edge E is presented after edge E+1; one request per cycle sustained.
// Backpressure: reqN_ready = queue N not full; cache_ready low freezes the output slot.
module cache_req_arb
  import cache_req_arb_pkg::*;
#(
  parameter int ADDR_W     = 48,
  parameter int OP_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [OP_W-1:0]   req1_op,
  output logic              cache_valid,
  input  logic              cache_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [OP_W-1:0]   cache_op,
  output logic              cache_src,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  illegal_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OP_W-1:0]   op;
  } port_req_t;

  localparam int RW = $bits(port_req_t);

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_READ)) || (op == OP_W'(OP_WRITE));
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Per-port queues
  logic      full0, empty0, push0, pop0, ill0;
  logic      full1, empty1, push1, pop1, ill1;
  port_req_t wr0, wr1, head0, head1;

  assign req0_ready = ~full0;
  assign req1_ready = ~full1;
  assign wr0        = '{addr: req0_addr, op: req0_op};
  assign wr1        = '{addr: req1_addr, op: req1_op};
  // Illegal ops are counted and dropped; they never occupy a queue slot.
  assign push0      = req0_valid && req0_ready &&  op_legal(req0_op);
  assign ill0       = req0_valid && req0_ready && !op_legal(req0_op);
  assign push1      = req1_valid && req1_ready &&  op_legal(req1_op);
  assign ill1       = req1_valid && req1_ready && !op_legal(req1_op);

  req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push0),
    .push_dat_i (wr0),
    .pop_i      (pop0),
    .full_o     (full0),
    .empty_o    (empty0),
    .head_o     (head0)
  );

  req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push1),
    .push_dat_i (wr1),
    .pop_i      (pop1),
    .full_o     (full1),
    .empty_o    (empty1),
    .head_o     (head1)
  );

  // Output slot and arbitration state
  logic      out_vld_q, out_vld_d;
  port_req_t out_q, out_d;
  logic      out_src_q, out_src_d;
  logic      last_grant_q, last_grant_d;
  logic      load, have, win, consume;

  logic [CNT_W-1:0] grant0_q, grant0_d, grant1_q, grant1_d, ill_q, ill_d;

  // Pick a winner and decide whether the output slot reloads this cycle.
  always_comb begin
    load         = !out_vld_q || cache_ready;
    have         = 1'b0;
    win          = 1'b0;
    out_vld_d    = out_vld_q;
    out_d        = out_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (!empty0 && !empty1) begin
      have = 1'b1;
      win  = ~last_grant_q;
    end else if (!empty0) begin
      have = 1'b1;
      win  = 1'b0;
    end else if (!empty1) begin
      have = 1'b1;
      win  = 1'b1;
    end
    pop0 = load && have && !win;
    pop1 = load && have &&  win;
    if (load) begin
      out_vld_d = have;
      if (have) begin
        out_d        = win ? head1 : head0;
        out_src_d    = win;
        last_grant_d = win;
      end
    end
  end

  assign consume = out_vld_q && cache_ready;

  // Saturating statistics updates.
  always_comb begin
    grant0_d = sat_add(grant0_q, {1'b0, consume && !out_src_q});
    grant1_d = sat_add(grant1_q, {1'b0, consume &&  out_src_q});
    ill_d    = sat_add(ill_q, {1'b0, ill0} + {1'b0, ill1});
  end

  // Register slot, arbitration pointer and counters; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q    <= 1'b0;
      out_q        <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      grant0_q     <= '0;
      grant1_q     <= '0;
      ill_q        <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      ill_q        <= ill_d;
    end
  end

  assign cache_valid = out_vld_q;
  assign cache_addr  = out_q.addr;
  assign cache_op    = out_q.op;
  assign cache_src   = out_src_q;
  assign grant_cnt0  = grant0_q;
  assign grant_cnt1  = grant1_q;
  assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_cache_req_arb.sv
// Bench for cache_req_arb: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_req_arb;
  import cache_req_arb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [47:0]       req0_addr = '0, req1_addr = '0;
  logic [7:0]        req0_op = '0, req1_op = '0;
  logic              cache_valid, cache_ready = 1'b0;
  logic [47:0]       cache_addr;
  logic [7:0]        cache_op;
  logic              cache_src;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1, illegal_cnt;

  int checks = 0;
  int errors = 0;

  cache_req_arb #(.ADDR_W(48), .OP_W(8), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_op(req1_op),
    .cache_valid(cache_valid), .cache_ready(cache_ready), .cache_addr(cache_addr),
    .cache_op(cache_op), .cache_src(cache_src),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: two bounded queues, one output slot, a round-robin pointer.
  req_t m_q0[$];
  req_t m_q1[$];
  bit   m_vld;
  req_t m_slot;
  bit   m_src;
  bit   m_lg;
  int   m_g0, m_g1, m_ill;

  function automatic bit legal(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_edge();
    req_t r0, r1;
    bit   acc0, acc1;
    int   w;
    if (reset) begin
      m_q0.delete(); m_q1.delete();
      m_vld = 0; m_slot = '0; m_src = 0; m_lg = 1;
      m_g0 = 0; m_g1 = 0; m_ill = 0;
      return;
    end
    acc0 = req0_valid && (m_q0.size() < DEPTH);
    acc1 = req1_valid && (m_q1.size() < DEPTH);
    r0.addr = req0_addr; r0.op = req0_op;
    r1.addr = req1_addr; r1.op = req1_op;
    if (m_vld && cache_ready) begin
      if (m_src == 0) m_g0 = sat(m_g0 + 1);
      else            m_g1 = sat(m_g1 + 1);
    end
    if (!m_vld || cache_ready) begin
      w = -1;
      if (m_q0.size() > 0 && m_q1.size() > 0) w = m_lg ? 0 : 1;
      else if (m_q0.size() > 0) w = 0;
      else if (m_q1.size() > 0) w = 1;
      if (w == 0) begin
        m_slot = m_q0.pop_front(); m_src = 0; m_vld = 1; m_lg = 0;
      end else if (w == 1) begin
        m_slot = m_q1.pop_front(); m_src = 1; m_vld = 1; m_lg = 1;
      end else begin
        m_vld = 0;
      end
    end
    if (acc0) begin
      if (legal(r0.op)) m_q0.push_back(r0);
      else m_ill = sat(m_ill + 1);
    end
    if (acc1) begin
      if (legal(r1.op)) m_q1.push_back(r1);
      else m_ill = sat(m_ill + 1);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    req0_valid = 0; req1_valid = 0;
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic test_reset();
    cache_ready = 0;
    do_reset(2);
    step();
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cache_valid); end
    checks++; if (cache_addr !== 48'h0) begin errors++; $display("FAIL reset_addr got %h want 0", cache_addr); end
    checks++; if (cache_op !== 8'h0) begin errors++; $display("FAIL reset_op got %h want 0", cache_op); end
    checks++; if (cache_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", cache_src); end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b%0b want 11", req0_ready, req1_ready); end
    checks++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || illegal_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", grant_cnt0, grant_cnt1, illegal_cnt); end
  endtask

  task automatic test_single();
    do_reset(1);
    cache_ready = 1;
    req0_valid = 1; req0_addr = 48'h0000_0000_1000; req0_op = OP_READ;
    step();
    req0_valid = 0;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0b want 0", cache_valid); end
    step();
    checks++; if (cache_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", cache_valid); end
    checks++; if (cache_src !== 1'b0 || cache_addr !== 48'h1000 || cache_op !== 8'h72) begin errors++; $display("FAIL single_data got src %0b addr %h op %h want 0 1000 72", cache_src, cache_addr, cache_op); end
    step();
    checks++; if (grant_cnt0 !== 5'd1 || grant_cnt1 !== 5'd0) begin errors++; $display("FAIL single_grant got %0d %0d want 1 0", grant_cnt0, grant_cnt1); end
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b want 0", cache_valid); end
  endtask

  task automatic test_round_robin();
    int sent0, sent1;
    bit a0, a1;
    bit order[$];
    do_reset(1);
    cache_ready = 1;
    sent0 = 0; sent1 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      req0_valid = (sent0 < 3); req0_addr = 48'h100 + 48'(sent0); req0_op = OP_READ;
      req1_valid = (sent1 < 3); req1_addr = 48'h200 + 48'(sent1); req1_op = OP_WRITE;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (cache_valid && cache_ready) order.push_back(cache_src);
      step();
      if (a0) sent0++;
      if (a1) sent1++;
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (order.size() != 6) begin errors++; $display("FAIL rr_count got %0d want 6", order.size()); end
    for (int i = 0; i < order.size() && i < 6; i++) begin
      checks++; if (order[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_order[%0d] got %0b want %0b", i, order[i], 1'(i % 2)); end
    end
    checks++; if (grant_cnt0 !== 5'd3 || grant_cnt1 !== 5'd3) begin errors++; $display("FAIL rr_grants got %0d %0d want 3 3", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [47:0] got[$];
    do_reset(1);
    cache_ready = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req1_valid = 1; req1_addr = 48'hA000 + 48'(i); req1_op = OP_WRITE;
      if (req1_ready) acc++;
      step();
    end
    req1_valid = 0;
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b want 0", req1_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cache_valid !== 1'b1 || cache_addr !== 48'hA000) begin errors++; $display("FAIL bp_hold got vld %0b addr %h want 1 a000", cache_valid, cache_addr); end
      step();
    end
    cache_ready = 1;
    for (int i = 0; i < 15; i++) begin
      if (cache_valid) got.push_back(cache_addr);
      step();
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_drain_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      checks++; if (got[i] !== 48'hA000 + 48'(i)) begin errors++; $display("FAIL bp_drain_order[%0d] got %h want %h", i, got[i], 48'hA000 + 48'(i)); end
    end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %0b want 1", req1_ready); end
  endtask

  task automatic test_illegal();
    do_reset(1);
    cache_ready = 1;
    req0_valid = 1; req0_addr = 48'hBAD; req0_op = 8'h41;
    step();
    req0_valid = 0;
    checks++; if (illegal_cnt !== 5'd1) begin errors++; $display("FAIL illegal_cnt got %0d want 1", illegal_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cache_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL illegal_dropped got vld %0b rdy %0b want 0 1", cache_valid, req0_ready); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    cache_ready = 0;
    req0_valid = 1; req0_op = OP_READ;
    req1_valid = 1; req1_op = 8'h00;
    req0_addr = 48'hC000; step();
    req1_valid = 0;
    req0_addr = 48'hC001; step();
    req0_valid = 0;
    checks++; if (cache_valid !== 1'b1 || illegal_cnt !== 5'd1) begin errors++; $display("FAIL mid_setup got vld %0b ill %0d want 1 1", cache_valid, illegal_cnt); end
    reset = 1; step(); reset = 0;
    checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", cache_valid); end
    checks++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0 || illegal_cnt !== '0) begin errors++; $display("FAIL mid_cnt got %0d %0d %0d want 0 0 0", grant_cnt0, grant_cnt1, illegal_cnt); end
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b%0b want 11", req0_ready, req1_ready); end
    cache_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %0b want 0", cache_valid); end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset(1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_addr = {16'($urandom), $urandom};
      req1_addr = {16'($urandom), $urandom};
      r = $urandom_range(0, 9); req0_op = (r == 0) ? 8'h41 : (r < 5) ? OP_READ : OP_WRITE;
      r = $urandom_range(0, 9); req1_op = (r == 0) ? 8'($urandom_range(0, 100)) : (r < 5) ? OP_READ : OP_WRITE;
      cache_ready = ((cyc / 64) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      step();
      checks++; if (req0_ready !== (m_q0.size() < DEPTH) || req1_ready !== (m_q1.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b%0b want %0b%0b", cyc, req0_ready, req1_ready, m_q0.size() < DEPTH, m_q1.size() < DEPTH); end
      checks++; if (cache_valid !== m_vld) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, cache_valid, m_vld); end
      if (m_vld) begin
        checks++; if (cache_addr !== m_slot.addr || cache_op !== m_slot.op || cache_src !== m_src) begin errors++; $display("FAIL rnd_data cyc %0d got %h %h %0b want %h %h %0b", cyc, cache_addr, cache_op, cache_src, m_slot.addr, m_slot.op, m_src); end
      end
      checks++; if (grant_cnt0 !== CNT_W'(m_g0) || grant_cnt1 !== CNT_W'(m_g1) || illegal_cnt !== CNT_W'(m_ill)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d %0d %0d want %0d %0d %0d", cyc, grant_cnt0, grant_cnt1, illegal_cnt, m_g0, m_g1, m_ill); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
